add_sub_acc: RTL and testbench
==============================

ADD_SUB_ACC -- requirements
Module: add_sub_acc

Interface
REQ-001 The block SHALL have one parameter: ACC_INIT, default 4'h0, reset value of the accumulator.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_valid  input  1  request strobe; qualifies i_op and i_data.
REQ-006 o_ready  output  1  block can accept a request.
REQ-007 i_op  input  2  opcode: 2'b00 ADD, 2'b01 SUB, 2'b10 LOAD, 2'b11 CLEAR.
REQ-008 i_data  input  4  operand.
REQ-009 o_as_a  output  4  adder operand A; always equals o_acc.
REQ-010 o_as_b  output  4  adder operand B; the latched operand.
REQ-011 o_as_s  output  1  adder subtract select; 1 when the latched op is SUB.
REQ-012 i_as_sum  input  4  adder sum, returned from the 4-bit add/sub stage.
REQ-013 i_as_cout  input  1  adder carry-out, returned from the 4-bit add/sub stage.
REQ-014 o_acc  output  4  accumulator.
REQ-015 o_c, o_v, o_z, o_n  output  1 each  carry, signed overflow, zero and negative flags.
REQ-016 o_done  output  1  one-cycle completion pulse.
REQ-017 o_ops  output  8  count of completed operations.

Function
REQ-018 The FSM SHALL have three states, IDLE, EXEC and DONE; reset state is IDLE.
REQ-019 o_ready SHALL be 1 only in IDLE.
REQ-020 A handshake SHALL occur when i_valid=1 and o_ready=1 at a rising edge.
REQ-021 On handshake, the block SHALL latch i_op and i_data into internal registers and go IDLE->EXEC.
REQ-022 In IDLE without a handshake, the FSM SHALL stay in IDLE.
REQ-023 EXEC SHALL last exactly one cycle and SHALL always be followed by DONE.
REQ-024 DONE SHALL last exactly one cycle, SHALL assert o_done=1, and SHALL always be followed by IDLE.
REQ-025 i_valid SHALL be ignored in EXEC and DONE: no latch, no queueing.
REQ-026 Maximum throughput SHALL be one operation per 3 cycles.
REQ-027 o_as_a, o_as_b and o_as_s SHALL be driven combinationally from registers in every state; i_as_sum and i_as_cout SHALL be sampled only at the EXEC->DONE edge.
REQ-028 At the end of EXEC for ADD or SUB: o_acc <= i_as_sum, o_c <= i_as_cout.
REQ-029 For SUB, o_c=1 SHALL mean no borrow.
REQ-030 For ADD or SUB, o_v <= (a[3]==beff[3]) && (i_as_sum[3]!=a[3]), where a is the old o_acc and beff = o_as_b ^ {4{o_as_s}}.
REQ-031 At the end of EXEC for LOAD: o_acc <= latched data, o_c <= 0, o_v <= 0; the adder result SHALL be ignored.
REQ-032 At the end of EXEC for CLEAR: o_acc <= 4'h0, o_c <= 0, o_v <= 0.
REQ-033 For all ops, o_z and o_n SHALL be computed from the new accumulator value: o_z = (value==0), o_n = value[3].
REQ-034 All result registers SHALL update in the same edge, so new values are visible in the DONE cycle together with o_done.
REQ-035 Total latency from handshake edge to o_done high SHALL be 2 cycles.
REQ-036 o_ops SHALL increment by 1 at the EXEC->DONE edge and SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-037 Arithmetic SHALL wrap modulo 16, with no saturation.

Reset
REQ-038 While i_rst_n=0, regardless of clock: state=IDLE, o_acc=ACC_INIT, o_c=o_v=0, o_z=(ACC_INIT==0), o_n=ACC_INIT[3], o_done=0, o_ops=0, and the latched op/data = 0.
REQ-039 A reset asserted in EXEC or DONE SHALL abort the operation: no o_done and no o_ops increment.
REQ-040 After reset release, o_ready=1 immediately and the first handshake is possible at the first rising edge.

Verification
REQ-041 Reset with ACC_INIT=4'h0 -> o_acc=0, o_z=1, o_c=o_v=o_n=0, o_ops=0, o_ready=1, o_done=0.
REQ-042 LOAD 4'h5 then ADD 4'h3 -> o_acc=4'h8, o_c=0, o_v=1, o_n=1, o_z=0, o_ops=2; o_done is high exactly 2 cycles after each handshake.
REQ-043 LOAD 4'h3 then SUB 4'h3 -> o_acc=0, o_c=1, o_z=1, o_v=0, o_n=0; LOAD 4'h2 then SUB 4'h5 -> o_acc=4'hD, o_c=0, o_n=1, o_v=0.
REQ-044 LOAD 4'hF then ADD 4'h1 -> o_acc=0, o_c=1, o_z=1, o_v=0; then CLEAR -> o_acc=0, o_c=0.
REQ-045 i_valid held at 1 for 9 cycles with alternating data -> exactly 3 handshakes, each taking the i_data present in an IDLE cycle; o_ready pattern is 1,0,0 repeating.
REQ-046 Reset pulsed during EXEC of ADD -> o_acc=ACC_INIT, no o_done, o_ops unchanged at 0; 256 completed ops -> o_ops wraps to 0.

Source files
------------

// File: rtl/add_sub_acc.sv
// Sequencer for an external 4-bit add/sub stage: latches one request, runs it through
// the adder for one cycle, and holds the accumulator, flags and an operation count.
//
// state | meaning
// IDLE  | ready; a valid request is latched here
// EXEC  | adder sees acc and latched operand; results captured at end of cycle
// DONE  | results visible, o_done pulses for one cycle
module add_sub_acc #(
    parameter logic [3:0] ACC_INIT = 4'h0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [1:0] i_op,
    input  logic [3:0] i_data,
    output logic [3:0] o_as_a,
    output logic [3:0] o_as_b,
    output logic       o_as_s,
    input  logic [3:0] i_as_sum,
    input  logic       i_as_cout,
    output logic [3:0] o_acc,
    output logic       o_c,
    output logic       o_v,
    output logic       o_z,
    output logic       o_n,
    output logic       o_done,
    output logic [7:0] o_ops
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q;
    logic [3:0] data_q;
    logic       hs;
    logic [3:0] beff;
    logic [3:0] acc_d;
    logic       c_d, v_d;

    assign o_ready = (state_q == IDLE);
    assign o_done  = (state_q == DONE);
    assign hs      = i_valid && o_ready;

    assign o_as_a = o_acc;
    assign o_as_b = data_q;
    assign o_as_s = (op_q == OP_SUB);
    assign beff   = o_as_b ^ {4{o_as_s}};

    // Zero/negative always track the accumulator, so they are correct in reset too.
    assign o_z = (o_acc == 4'h0);
    assign o_n = o_acc[3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = o_acc;
        c_d   = o_c;
        v_d   = o_v;
        case (op_q)
            OP_ADD, OP_SUB: begin
                acc_d = i_as_sum;
                c_d   = i_as_cout;
                v_d   = (o_as_a[3] == beff[3]) && (i_as_sum[3] != o_as_a[3]);
            end
            OP_LOAD: begin
                acc_d = data_q;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            OP_CLEAR: begin
                acc_d = 4'h0;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            default: begin
                acc_d = o_acc;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q   <= 2'b00;
            data_q <= 4'h0;
        end else if (hs) begin
            op_q   <= i_op;
            data_q <= i_data;
        end
    end

    // Adder return is sampled only on the EXEC->DONE edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_acc <= ACC_INIT;
            o_c   <= 1'b0;
            o_v   <= 1'b0;
            o_ops <= 8'h00;
        end else if (state_q == EXEC) begin
            o_acc <= acc_d;
            o_c   <= c_d;
            o_v   <= v_d;
            o_ops <= o_ops + 8'h01;
        end
    end

endmodule

// File: tb/tb_add_sub_acc.sv
// Scoreboard bench for add_sub_acc: driver queues hand-computed results per request,
// a negedge monitor pops and compares whenever o_done is seen.
module tb_add_sub_acc;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_op;
    logic [3:0] i_data;
    logic [3:0] o_as_a, o_as_b;
    logic       o_as_s;
    logic [3:0] i_as_sum;
    logic       i_as_cout;
    logic [3:0] o_acc;
    logic       o_c, o_v, o_z, o_n, o_done;
    logic [7:0] o_ops;
    logic [4:0] add_res;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

    add_sub_acc #(.ACC_INIT(4'h0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_data(i_data), .o_as_a(o_as_a), .o_as_b(o_as_b), .o_as_s(o_as_s),
        .i_as_sum(i_as_sum), .i_as_cout(i_as_cout), .o_acc(o_acc), .o_c(o_c), .o_v(o_v),
        .o_z(o_z), .o_n(o_n), .o_done(o_done), .o_ops(o_ops)
    );

    always #5 i_clk = ~i_clk;

    // External 4-bit add/sub stage: a + (b ^ s) + s
    always_comb add_res = {1'b0, o_as_a} + {1'b0, o_as_b ^ {4{o_as_s}}} + {4'b0, o_as_s};
    assign i_as_sum  = add_res[3:0];
    assign i_as_cout = add_res[4];

    typedef struct {
        logic [3:0] acc;
        logic       c, v, z, n;
        logic [7:0] ops;
        int         hs_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] acc, input logic c, input logic v, input logic [7:0] ops);
        exp_t e;
        e.acc = acc; e.c = c; e.v = v; e.z = (acc == 4'h0); e.n = acc[3];
        e.ops = ops; e.hs_cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!o_ready && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_ready) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: o_ready still %0b after %0d cycles", o_ready, t);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [3:0] d, input logic [3:0] e_acc,
                         input logic e_c, input logic e_v, input logic [7:0] e_ops);
        wait_ready();
        i_valid = 1'b1; i_op = op; i_data = d;
        push_exp(e_acc, e_c, e_v, e_ops);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Monitor: every o_done must match the oldest queued expectation, two cycles after its handshake.
    always @(negedge i_clk) begin
        if (o_done) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: o_done=1 with no request outstanding (acc %0h ops %0h)", o_acc, o_ops);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result{acc,c,v,z,n,ops}", {16'h0, o_acc, o_c, o_v, o_z, o_n, o_ops},
                      {16'h0, e.acc, e.c, e.v, e.z, e.n, e.ops});
                check("done_latency", cyc - e.hs_cyc, 2);
            end
        end
    end

    initial begin
        int t;
        logic [3:0] nv;
        i_rst_n = 1'b0; i_valid = 1'b0; i_op = 2'b00; i_data = 4'h0;
        repeat (2) @(negedge i_clk);
        check("reset_flags{acc,c,v,z,n,done}", {o_acc, o_c, o_v, o_z, o_n, o_done}, {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check("reset_ops", o_ops, 8'h00);
        i_rst_n = 1'b1;
        check("ready_after_reset", o_ready, 1'b1);

        do_op(LOAD, 4'h5, 4'h5, 1'b0, 1'b0, 8'd1);
        do_op(ADD,  4'h3, 4'h8, 1'b0, 1'b1, 8'd2);
        do_op(LOAD, 4'h3, 4'h3, 1'b0, 1'b0, 8'd3);
        do_op(SUB,  4'h3, 4'h0, 1'b1, 1'b0, 8'd4);
        do_op(LOAD, 4'h2, 4'h2, 1'b0, 1'b0, 8'd5);
        do_op(SUB,  4'h5, 4'hD, 1'b0, 1'b0, 8'd6);
        do_op(LOAD, 4'hF, 4'hF, 1'b0, 1'b0, 8'd7);
        do_op(ADD,  4'h1, 4'h0, 1'b1, 1'b0, 8'd8);
        do_op(CLR,  4'h9, 4'h0, 1'b0, 1'b0, 8'd9);
        do_op(ADD,  4'h7, 4'h7, 1'b0, 1'b0, 8'd10);
        do_op(ADD,  4'h1, 4'h8, 1'b0, 1'b1, 8'd11);
        do_op(SUB,  4'h1, 4'h7, 1'b1, 1'b1, 8'd12);

        // Valid held for 9 cycles with alternating data: only IDLE cycles are taken.
        wait_ready();
        for (int j = 0; j < 9; j++) begin
            i_valid = 1'b1; i_op = LOAD;
            i_data  = (j % 2 == 0) ? 4'hA : 4'h5;
            check("ready_pattern", o_ready, (j % 3 == 0));
            if (j % 3 == 0) push_exp(i_data, 1'b0, 1'b0, 8'(13 + j / 3));
            @(negedge i_clk);
        end
        i_valid = 1'b0;

        // Reset during EXEC of an ADD aborts it.
        wait_ready();
        i_valid = 1'b1; i_op = ADD; i_data = 4'h3;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("in_exec_before_abort", o_ready, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check("abort_acc", o_acc, 4'h0);
        check("abort_ops", o_ops, 8'h00);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("ready_after_abort", o_ready, 1'b1);
        repeat (4) @(negedge i_clk);
        check("ops_after_abort", o_ops, 8'h00);

        // 256 ADD 1 ops: accumulator wraps every 16, counter wraps to 0.
        for (int i = 0; i < 256; i++) begin
            nv = 4'((i + 1) % 16);
            do_op(ADD, 4'h1, nv, (nv == 4'h0), (nv == 4'h8), 8'((i + 1) % 256));
        end

        t = 0;
        while (sb_q.size() != 0 && t < 10) begin
            @(negedge i_clk);
            t++;
        end
        check("scoreboard_drained", sb_q.size(), 0);
        check("ops_wrapped", o_ops, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
